// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response handshake bundle between a datapath memory stage
//   (master) and the data memory responder (slave).
//   Request  : req_valid, req_ready, req_write, req_addr[15:0], req_wdata[15:0]
//   Response : resp_valid, resp_ready, resp_rdata[15:0], resp_err
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle word-addressed 16-bit data memory with a fixed number of
//   wait states and a single outstanding transaction.
//   Parameters:
//     DEPTH       - number of 16-bit words (valid addresses 0..DEPTH-1)
//     WAIT_CYCLES - wait states between accept and response (0..15)
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous active-high reset
//     bus   - slave side of data_mem_responder_if (request/response handshake)
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_EXT  = 17'(DEPTH);
  localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [15:0] r_mem [DEPTH];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_resp_done;
  logic        w_cur_write;
  logic [15:0] w_cur_addr;
  logic [15:0] w_cur_wdata;
  logic        w_addr_err;
  logic [AW-1:0] w_idx;

  // With zero wait states the memory access happens on the accept edge
  // itself, before the captured registers are valid, so the live request
  // fields are used while still in IDLE.
  assign w_cur_write = (r_state == S_IDLE) ? bus.req_write : r_write;
  assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  // Full 16-bit range check so out-of-range addresses never alias.
  assign w_addr_err  = ({1'b0, w_cur_addr} >= DEPTH_EXT);
  assign w_idx       = w_cur_addr[AW-1:0];

  // Handshake outputs decode only from the state register.
  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_resp_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (!w_cur_write && !w_addr_err) ? r_mem[w_idx] : 16'd0;
        r_err   <= w_addr_err;
      end else if (w_resp_done) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Storage is never cleared; reset only suppresses a write on its edge.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_cur_write && !w_addr_err) begin
      r_mem[w_idx] <= w_cur_wdata;
    end
  end

endmodule
